dac_frame_scheduler: RTL and testbench
======================================

# dac_frame_scheduler

- Frame sequencer for the Digilent PMOD-DA2 output path. Runs entirely in the selected converter clock domain.
- Divides `clk_selected` into a serial bit clock and frames each 32-bit stereo sample into a SYNC/SCLK/DINA/DINB transfer.
- Pulls samples from the upstream sample buffer with a valid/ready handshake and reports underflows.
- Sits between the byte-to-sample assembly logic and the PMOD connector, replacing free-running sample-clock strobes with an explicit per-frame request.

## Interface
Parameters:
- `IDLE_BITS`, default 4: bit periods with SYNC high between frames; legal range 1–15.
- `WORD_BITS`, default 16: bits shifted per channel per frame; fixed at 16 for the DA2.

Ports:
- `clk_selected`  in  1  converter clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run/stop; sampled every cycle.
- `clkdiv`  in  4  bit-clock tick every 2^clkdiv cycles; 0 = every cycle.
- `mute_on_underflow`  in  1  1 = send zeros on underflow; 0 = repeat last sample.
- `sample_data`  in  32  {left[31:16], right[15:0]}, unsigned DAC codes, MSB first.
- `sample_valid`  in  1  upstream holds a sample.
- `sample_ready`  out  1  one-cycle pulse; the sample is consumed when both `sample_ready` and `sample_valid` are high.
- `pmod_io`  out  4  [3]=SCLK, [2]=DINB (right), [1]=DINA (left), [0]=SYNC (active low).
- `frame_start`  out  1  one-cycle pulse in the LOAD cycle.
- `underflow`  out  1  one-cycle pulse when LOAD finds `sample_valid` low.

## Operation
States:
- **IDLE:** entered on reset or whenever `enable`=0, from any state, on the next edge. Mid-frame aborts are allowed; the frame is discarded. Outputs: SCLK=1, SYNC=1, DIN=0, divider cleared. Leaves to GAP when `enable`=1.
- **GAP:** SYNC=1, DIN=0. SCLK toggles on every tick. Counts `IDLE_BITS` full bit periods, each ending on the tick where SCLK returns to 1, then goes to LOAD.
- **LOAD:** lasts exactly one cycle, with no tick consumed.
  - Asserts `sample_ready` and `frame_start`.
  - If `sample_valid`=1: captures `sample_data` into the left/right shift registers and into the last-sample register.
  - Otherwise: pulses `underflow` and loads the last-sample register, or 0 if `mute_on_underflow`=1.
  - Next state is SHIFT with bit index 15.
- **SHIFT:** SYNC=0 from the first SHIFT cycle. DINA/DINB present bit[index] of left/right.
  - Each SCLK 1→0 tick is the DAC sampling edge.
  - On each 0→1 tick the index decrements.
  - After the falling tick of bit 0 and the following rising tick, the state goes to GAP (SYNC=1) at that tick.

Divider and widths:
- Divider is a 16-bit counter. A tick occurs when counter == (1<<clkdiv)-1, and the counter then clears.
- A `clkdiv` change takes effect at the next counter clear; the current count is never truncated.
- Bit index is 4 bits; the gap counter is 4 bits.
- Last-sample register resets to 0.

## Timing
- All outputs are registered and reset to: `pmod_io`=4'b1001, `sample_ready`=0, `frame_start`=0, `underflow`=0.
- Frame length = 2^clkdiv × 2 × (16 + IDLE_BITS) + 1 cycles. The +1 is the LOAD cycle.
- With clkdiv=0 and IDLE_BITS=4, the frame length is 41 cycles.
- From `enable` rising to the first `frame_start`: 1 + 2×IDLE_BITS×2^clkdiv cycles.
- `sample_valid` rising during SHIFT/GAP is not consumed until the next LOAD. Upstream must hold data stable.
- Reset asserted mid-frame gives IDLE outputs on the next edge.

## Configuration
- `DAC_UNDERFLOW_COUNT_EN` defined: adds output `underflow_count` (16 bits).
  - Increments on each `underflow` pulse and saturates at 16'hFFFF.
  - Cleared by `reset` only.
- Undefined: the port and counter are absent. The `underflow` pulse is unchanged.

## Structure
- Shared package `dac_pkg`:
  - state enum `dac_frame_state_t` (IDLE, GAP, LOAD, SHIFT);
  - PMOD bit-index constants `PMOD_SCLK`=3, `PMOD_DINB`=2, `PMOD_DINA`=1, `PMOD_SYNC`=0;
  - reset value `PMOD_IDLE`=4'b1001.
- One sub-module, `dac_bit_clk_div`: inputs clk, reset, clear, clkdiv; output one-cycle `tick`.

## Test plan
- Reset then `enable`=1, clkdiv=0, IDLE_BITS=4, valid held with 32'hA5A5_0F0F:
  - first `frame_start` at cycle 9;
  - DINA shows A5A5 and DINB shows 0F0F MSB-first on 16 SCLK falling edges;
  - SYNC low exactly 32 cycles.
- `sample_valid`=0 at LOAD with last sample 32'h1234_5678 and mute=0 → `underflow` pulse; frame repeats 1234/5678.
- Same case with mute=1 → `underflow` pulse; both lines 0 for the whole frame.
- clkdiv=2 → SCLK period 8 cycles; frame 161 cycles apart. Change clkdiv to 0 mid-bit → old period completes, then 2-cycle period.
- Deassert `enable` at bit 7 of SHIFT → next edge `pmod_io`=4'b1001. Re-enable → full GAP before LOAD; no sample consumed in the aborted frame.
- With `DAC_UNDERFLOW_COUNT_EN`: 3 starved frames → `underflow_count`=3. Preloaded at 16'hFFFF and starved again → stays 16'hFFFF.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the PMOD-DA2 frame path: frame state encoding,
// pmod_io bit positions and the idle line levels.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    LOAD,
    SHIFT
  } dac_frame_state_t;

  localparam int PMOD_SCLK = 3;
  localparam int PMOD_DINB = 2;
  localparam int PMOD_DINA = 1;
  localparam int PMOD_SYNC = 0;

  localparam logic [3:0] PMOD_IDLE = 4'b1001;

  // Terminal count of the bit-clock divider for a given clkdiv setting.
  function automatic logic [15:0] div_limit(input logic [3:0] clkdiv);
    return (16'd1 << clkdiv) - 16'd1;
  endfunction

  function automatic logic [3:0] pmod_pack(input logic sclk, input logic dinb,
                                           input logic dina, input logic sync);
    logic [3:0] w;
    w            = '0;
    w[PMOD_SCLK] = sclk;
    w[PMOD_DINB] = dinb;
    w[PMOD_DINA] = dina;
    w[PMOD_SYNC] = sync;
    return w;
  endfunction

endpackage

// File: rtl/dac_bit_clk_div.sv
// Bit-clock tick generator: one tick every 2^clkdiv cycles. A new clkdiv is only
// adopted when the count clears, so a running period is never cut short.
module dac_bit_clk_div
  import dac_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] clkdiv,
  output logic       tick
);

  logic [15:0] count_reg;
  logic [3:0]  div_reg;

  assign tick = !clear && (count_reg == div_limit(div_reg));

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      count_reg <= '0;
      div_reg   <= clkdiv;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// PMOD-DA2 frame sequencer: GAP (SYNC high) -> LOAD (one-cycle sample request) ->
// SHIFT (16 bits per channel, MSB first). Optional DAC_UNDERFLOW_COUNT_EN adds underflow_count.
module dac_frame_scheduler
  import dac_pkg::*;
#(
  parameter int IDLE_BITS = 4,
  parameter int WORD_BITS = 16
) (
  input  logic        clk_selected,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  clkdiv,
  input  logic        mute_on_underflow,
  input  logic [31:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [3:0]  pmod_io,
  output logic        frame_start,
  output logic        underflow
`ifdef DAC_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam logic [3:0] GAP_LAST = 4'(IDLE_BITS - 1);
  localparam logic [3:0] LAST_BIT = 4'(WORD_BITS - 1);

  dac_frame_state_t state_reg;
  logic [3:0]  pmod_reg;
  logic        sample_ready_reg;
  logic        frame_start_reg;
  logic        underflow_reg;
  logic [3:0]  bit_idx_reg;
  logic [3:0]  gap_cnt_reg;
  logic [15:0] left_reg;
  logic [15:0] right_reg;
  logic [31:0] last_reg;
  logic [31:0] load_data;
  logic        div_clear;
  logic        tick;

  // The divider is held at zero in LOAD so the frame gains exactly one cycle there.
  assign div_clear = (state_reg == IDLE) || (state_reg == LOAD);

  dac_bit_clk_div u_div (
    .clk    (clk_selected),
    .reset  (reset),
    .clear  (div_clear),
    .clkdiv (clkdiv),
    .tick   (tick)
  );

  always_comb begin
    load_data = sample_valid ? sample_data : (mute_on_underflow ? 32'd0 : last_reg);
  end

  always_ff @(posedge clk_selected) begin
    if (reset) begin
      state_reg        <= IDLE;
      pmod_reg         <= PMOD_IDLE;
      sample_ready_reg <= 1'b0;
      frame_start_reg  <= 1'b0;
      underflow_reg    <= 1'b0;
      bit_idx_reg      <= LAST_BIT;
      gap_cnt_reg      <= '0;
      left_reg         <= '0;
      right_reg        <= '0;
      last_reg         <= '0;
    end else begin
      sample_ready_reg <= 1'b0;
      frame_start_reg  <= 1'b0;
      underflow_reg    <= 1'b0;
      if (!enable) begin
        state_reg   <= IDLE;
        pmod_reg    <= PMOD_IDLE;
        gap_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= GAP;
            gap_cnt_reg <= '0;
          end
          GAP: begin
            if (tick) begin
              pmod_reg[PMOD_SCLK] <= ~pmod_reg[PMOD_SCLK];
              // A gap bit period ends on the tick that brings SCLK back high.
              if (!pmod_reg[PMOD_SCLK]) begin
                if (gap_cnt_reg == GAP_LAST) begin
                  state_reg        <= LOAD;
                  sample_ready_reg <= 1'b1;
                  frame_start_reg  <= 1'b1;
                  gap_cnt_reg      <= '0;
                end else begin
                  gap_cnt_reg <= gap_cnt_reg + 4'd1;
                end
              end
            end
          end
          LOAD: begin
            left_reg    <= load_data[31:16];
            right_reg   <= load_data[15:0];
            bit_idx_reg <= LAST_BIT;
            if (sample_valid) begin
              last_reg <= sample_data;
            end else begin
              underflow_reg <= 1'b1;
            end
            pmod_reg  <= pmod_pack(1'b1, load_data[15], load_data[31], 1'b0);
            state_reg <= SHIFT;
          end
          SHIFT: begin
            if (tick) begin
              if (pmod_reg[PMOD_SCLK]) begin
                pmod_reg[PMOD_SCLK] <= 1'b0;
              end else if (bit_idx_reg == 4'd0) begin
                state_reg   <= GAP;
                pmod_reg    <= PMOD_IDLE;
                gap_cnt_reg <= '0;
              end else begin
                bit_idx_reg <= bit_idx_reg - 4'd1;
                pmod_reg    <= pmod_pack(1'b1, right_reg[bit_idx_reg - 4'd1],
                                         left_reg[bit_idx_reg - 4'd1], 1'b0);
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef DAC_UNDERFLOW_COUNT_EN
  logic [15:0] uf_count_reg;

  always_ff @(posedge clk_selected) begin
    if (reset) begin
      uf_count_reg <= '0;
    end else if (underflow_reg && (uf_count_reg != 16'hFFFF)) begin
      uf_count_reg <= uf_count_reg + 16'd1;
    end
  end

  assign underflow_count = uf_count_reg;
`endif

  assign pmod_io      = pmod_reg;
  assign sample_ready = sample_ready_reg;
  assign frame_start  = frame_start_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler: LOAD requests push expected frames,
// a serial decoder on pmod_io pops and compares them.
module tb_dac_frame_scheduler;

  localparam int IDLE_BITS = 4;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          uf;
    int          nbits;
    int          sync_len;
  } exp_t;

  logic        clk_selected = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  clkdiv = 4'd0;
  logic        mute_on_underflow = 1'b0;
  logic [31:0] sample_data = 32'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [3:0]  pmod_io;
  logic        frame_start;
  logic        underflow;
`ifdef DAC_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_count;
`endif

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   fs_t[$];
  int   sclk_t[$];
  bit   sync_check_en = 1'b1;
  bit   abort_next = 1'b0;
  int   abort_bits = 16;
  logic [31:0] last_m = 32'd0;
  int   uf_events = 0;
  int   ready_pulses = 0;

  dac_frame_scheduler #(.IDLE_BITS(IDLE_BITS), .WORD_BITS(16)) dut (
    .clk_selected      (clk_selected),
    .reset             (reset),
    .enable            (enable),
    .clkdiv            (clkdiv),
    .mute_on_underflow (mute_on_underflow),
    .sample_data       (sample_data),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready),
    .pmod_io           (pmod_io),
    .frame_start       (frame_start),
    .underflow         (underflow)
`ifdef DAC_UNDERFLOW_COUNT_EN
    ,
    .underflow_count   (underflow_count)
`endif
  );

  always #5 clk_selected = ~clk_selected;
  always @(posedge clk_selected) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic int frame_len(input int k);
    return (1 << k) * 2 * (16 + IDLE_BITS) + 1;
  endfunction

  // Reference model: each granted request yields the offered sample, or the
  // remembered / silent sample when nothing was offered.
  always @(negedge clk_selected) begin
    if (reset) begin
      last_m    = 32'd0;
      uf_events = 0;
    end else if (sample_ready) begin
      exp_t e;
      ready_pulses++;
      if (sample_valid) begin
        {e.l, e.r} = sample_data;
        e.uf       = 1'b0;
        last_m     = sample_data;
      end else begin
        {e.l, e.r} = mute_on_underflow ? 32'd0 : last_m;
        e.uf       = 1'b1;
        uf_events++;
      end
      e.nbits    = abort_next ? abort_bits : 16;
      e.sync_len = (abort_next || !sync_check_en) ? -1 : (32 << clkdiv);
      exp_q.push_back(e);
    end
  end

  // Monitor: decode SYNC-framed serial words, sampling DIN on SCLK falling edges.
  logic        prev_sync = 1'b1;
  logic        prev_sclk = 1'b1;
  int          nb = 0;
  int          slen = 0;
  logic [15:0] lw = 16'd0;
  logic [15:0] rw = 16'd0;
  bit          uf_seen = 1'b0;

  always @(negedge clk_selected) begin
    if (frame_start === 1'b1) fs_t.push_back(cyc);
    if (pmod_io[3] !== prev_sclk) sclk_t.push_back(cyc);
    if (pmod_io[0] === 1'b0) begin
      if (prev_sync) begin
        nb = 0; slen = 0; lw = 16'd0; rw = 16'd0; uf_seen = 1'b0;
      end
      slen++;
      if (underflow === 1'b1) uf_seen = 1'b1;
      if (prev_sclk && (pmod_io[3] === 1'b0)) begin
        lw = {lw[14:0], pmod_io[1]};
        rw = {rw[14:0], pmod_io[2]};
        nb++;
      end
    end else if (!prev_sync) begin
      if (exp_q.size() == 0) begin
        check("frame_without_request", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bit_count", nb, e.nbits);
        check("dina_word", lw, e.l >> (16 - e.nbits));
        check("dinb_word", rw, e.r >> (16 - e.nbits));
        check("underflow_flag", uf_seen, e.uf);
        if (e.sync_len >= 0) check("sync_low_cycles", slen, e.sync_len);
        $display("frame L=%h R=%h bits=%0d underflow=%0d sync_low=%0d", lw, rw, nb, uf_seen, slen);
      end
    end
    prev_sync = pmod_io[0];
    prev_sclk = pmod_io[3];
  end

  task automatic step();
    @(negedge clk_selected);
    #1;
  endtask

  task automatic after_load();
    @(posedge clk_selected);
    #1;
  endtask

  task automatic wait_fs(input int budget, output int t);
    int n0;
    n0 = fs_t.size();
    t  = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (fs_t.size() > n0) begin
        t = fs_t[n0];
        return;
      end
    end
    check("frame_start_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_sync(input logic level, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pmod_io[0] === level) return;
      step();
    end
    check("sync_wait_timeout", 64'd0, 64'd1);
  endtask

  // Retarget clkdiv across whole frames so no checked SYNC window straddles the change.
  task automatic set_div(input logic [3:0] d);
    int t;
    sync_check_en = 1'b0;
    wait_fs(2000, t);
    after_load();
    clkdiv = d;
    wait_fs(2000, t);
    after_load();
    sync_check_en = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run still active, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, en_edge, base, r0;

    reset = 1'b1; enable = 1'b0; clkdiv = 4'd0; mute_on_underflow = 1'b0;
    sample_valid = 1'b1; sample_data = 32'hA5A5_0F0F;
    repeat (3) step();
    check("reset_pmod_io", pmod_io, 4'b1001);
    check("reset_sample_ready", sample_ready, 1'b0);
    check("reset_frame_start", frame_start, 1'b0);
    check("reset_underflow", underflow, 1'b0);
`ifdef DAC_UNDERFLOW_COUNT_EN
    check("reset_underflow_count", underflow_count, 16'd0);
`endif
    reset = 1'b0;
    step();

    // Held sample, clkdiv=0: start latency and frame period.
    enable = 1'b1; en_edge = cyc + 1;
    wait_fs(200, t);
    check("first_frame_start_cycle", t - en_edge + 1, 1 + 2 * IDLE_BITS);
    wait_fs(200, t2);
    check("frame_period_div0", t2 - t, frame_len(0));
    wait_fs(200, t);

    // Underflow: repeat last sample, then mute.
    after_load();
    sample_data = 32'h1234_5678;
    wait_fs(200, t);
    after_load();
    sample_valid = 1'b0;
    wait_fs(200, t);
    after_load();
    mute_on_underflow = 1'b1;
    wait_fs(200, t);
    after_load();
    mute_on_underflow = 1'b0;
    sample_valid = 1'b1;
    sample_data = $urandom;

    // Randomized feed with occasional starvation at clkdiv=1.
    set_div(4'd1);
    for (int i = 0; i < 12; i++) begin
      wait_fs(400, t);
      after_load();
      mute_on_underflow = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        sample_valid = 1'b0;
      end else begin
        sample_valid = 1'b1;
        sample_data  = $urandom;
      end
    end
    sample_valid = 1'b1;
    sample_data  = $urandom;

    // clkdiv=2 frame period, then a mid-bit change back to 0.
    set_div(4'd2);
    wait_fs(2000, t);
    sync_check_en = 1'b0;
    wait_fs(2000, t2);
    check("frame_period_div2", t2 - t, frame_len(2));
    wait_sync(1'b0, 50);
    base = sclk_t.size();
    for (int i = 0; i < 50 && sclk_t.size() <= base; i++) step();
    clkdiv = 4'd0;
    for (int i = 0; i < 50 && sclk_t.size() <= base + 2; i++) step();
    if (sclk_t.size() > base + 2) begin
      check("sclk_half_period_old", sclk_t[base + 1] - sclk_t[base], 4);
      check("sclk_half_period_new", sclk_t[base + 2] - sclk_t[base + 1], 1);
    end else begin
      check("sclk_edge_timeout", sclk_t.size() - base, 3);
    end
    wait_fs(2000, t);
    after_load();
    sync_check_en = 1'b1;

    // Abort during bit 7 of SHIFT, then re-enable.
    sample_data = $urandom;
    abort_bits = 8;
    abort_next = 1'b1;
    wait_fs(200, t);
    abort_next = 1'b0;
    repeat (17) step();
    enable = 1'b0;
    step();
    check("abort_pmod_io", pmod_io, 4'b1001);
    r0 = ready_pulses;
    repeat (5) step();
    check("abort_no_request_while_idle", ready_pulses - r0, 0);
    sample_data = $urandom;
    enable = 1'b1; en_edge = cyc + 1;
    wait_fs(200, t);
    check("reenable_frame_start_cycle", t - en_edge + 1, 1 + 2 * IDLE_BITS);
    check("reenable_single_request", ready_pulses - r0, 1);

    // Reset mid-frame, then starved frames from a cleared last sample.
    after_load();
    abort_bits = 2;
    abort_next = 1'b1;
    wait_fs(200, t);
    abort_next = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    check("reset_midframe_pmod_io", pmod_io, 4'b1001);
    sample_valid = 1'b0;
    reset = 1'b0;
    repeat (3) wait_fs(200, t);
    repeat (4) step();
`ifdef DAC_UNDERFLOW_COUNT_EN
    check("underflow_count_three", underflow_count, 16'(uf_events));
    check("underflow_count_three_abs", underflow_count, 16'd3);
    force dut.uf_count_reg = 16'hFFFF;
    step();
    release dut.uf_count_reg;
    wait_fs(200, t);
    repeat (4) step();
    check("underflow_count_saturated", underflow_count, 16'hFFFF);
`endif

    // Let the last frame drain, then stop in the gap.
    wait_fs(200, t);
    wait_sync(1'b0, 200);
    wait_sync(1'b1, 200);
    enable = 1'b0;
    repeat (4) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
